npu_vec_engine: RTL and testbench

- Parametrised successor to the single-word ML accelerator: a vector engine with local operand banks A and B, a result bank C, and LANES int8 lanes per word.
- Executes DOT, ADD, MAX and RELU_DOT over up to DEPTH words per command, using a start/ready/done handshake.
- Sits beside the softcore; the host fills the banks through a word memory port, issues start, waits for done, then reads result or bank C.

---
 rtl/npu_vec_engine_if.sv | 36 +++
 rtl/npu_vec_engine.sv | 235 +++++++++++++++++++++++
 tb/tb_npu_vec_engine.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_vec_engine_if.sv
// npu_vec_engine_if: host-side bundle for the NPU vector engine.
// Carries the command handshake (start/ready/done) and the bank memory port.
// master = host/softcore side, slave = engine side.
interface npu_vec_engine_if #(
    parameter int LANES = 4,
    parameter int DEPTH = 64
);
    localparam int W  = 8 * LANES;
    localparam int AW = $clog2(DEPTH);

    logic          start;
    logic [1:0]    op_mode;
    logic [AW:0]   len_in;
    logic [31:0]   bias_in;
    logic [AW+1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [W-1:0]  mem_data_in;
    logic [W-1:0]  mem_data_out;
    logic [31:0]   result;
    logic          ready;
    logic          done;
    logic          sat_flag;

    modport master (
        output start, op_mode, len_in, bias_in,
        output mem_addr, mem_we, mem_re, mem_data_in,
        input  mem_data_out, result, ready, done, sat_flag
    );

    modport slave (
        input  start, op_mode, len_in, bias_in,
        input  mem_addr, mem_we, mem_re, mem_data_in,
        output mem_data_out, result, ready, done, sat_flag
    );
endinterface

// File: rtl/npu_vec_engine.sv
// npu_vec_engine: LANES x int8 vector engine (DOT/ADD/MAX/RELU_DOT) over banks A,B -> C.
// Ports: clk, rst (async high), bus (slave): start/op_mode/len_in/bias_in command,
//   mem_addr/mem_we/mem_re/mem_data_in/mem_data_out bank port, result/ready/done/sat_flag.
// Optional ML_ACC_PERF_CNT_EN: busy-cycle counter at status word 1.
module npu_vec_engine #(
    parameter int LANES = 4,
    parameter int DEPTH = 64,
    parameter int ACC_W = 32
) (
    input logic              clk,
    input logic              rst,
    npu_vec_engine_if.slave  bus
);
    localparam int W  = 8 * LANES;
    localparam int AW = $clog2(DEPTH);

    localparam logic signed [33:0] ACC_MAX = (34'sd1 <<< (ACC_W - 1)) - 34'sd1;
    localparam logic signed [33:0] ACC_MIN = -(34'sd1 <<< (ACC_W - 1));
    localparam logic [AW:0]        LEN_MAX = (AW + 1)'(DEPTH);

    localparam logic [1:0] OP_DOT  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_MAX  = 2'b10;
    localparam logic [1:0] OP_RELU = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    logic [W-1:0] bank_a [DEPTH];
    logic [W-1:0] bank_b [DEPTH];
    logic [W-1:0] bank_c [DEPTH];

    state_t             state;
    logic               ready_q, done_q, sat_q;
    logic [31:0]        result_q;
    logic [W-1:0]       rdata_q;
    logic [1:0]         op_r;
    logic [AW:0]        len_r;
    logic [AW-1:0]      idx;
    logic signed [31:0] acc;
    logic signed [7:0]  mx;
    logic [31:0]        sat_cnt;
    logic               s1_vld;
    logic signed [31:0] s1_dot;
    logic signed [7:0]  s1_max;
    logic [7:0]         s1_sat;
    logic [31:0]        perf_cnt;

    logic [1:0]    bank;
    logic [AW-1:0] word;
    assign bank = bus.mem_addr[AW+1:AW];
    assign word = bus.mem_addr[AW-1:0];

    assign bus.ready        = ready_q;
    assign bus.done         = done_q;
    assign bus.result       = result_q;
    assign bus.sat_flag     = sat_q;
    assign bus.mem_data_out = rdata_q;

    // Clamp to the signed ACC_W range; bit 32 flags that clamping happened.
    function automatic logic [32:0] sat_acc(input logic signed [33:0] v);
        if (v > ACC_MAX)
            return {1'b1, ACC_MAX[31:0]};
        else if (v < ACC_MIN)
            return {1'b1, ACC_MIN[31:0]};
        else
            return {1'b0, v[31:0]};
    endfunction

    // Stage-1 lane datapath on the current word pair.
    logic [W-1:0]       a_w, b_w, c_w;
    logic signed [31:0] w_dot;
    logic signed [7:0]  w_max;
    logic [7:0]         w_sat;
    logic signed [7:0]  ta, tb;
    logic signed [15:0] tp;
    logic [8:0]         ts;

    always_comb begin
        a_w   = bank_a[idx];
        b_w   = bank_b[idx];
        c_w   = '0;
        w_dot = '0;
        w_max = 8'sh80;
        w_sat = '0;
        ta    = '0;
        tb    = '0;
        tp    = '0;
        ts    = '0;
        for (int l = 0; l < LANES; l++) begin
            ta    = a_w[8*l +: 8];
            tb    = b_w[8*l +: 8];
            tp    = ta * tb;
            w_dot = w_dot + {{16{tp[15]}}, tp};
            // 9-bit sum; top two bits disagree when the int8 result overflows
            ts = {ta[7], ta} + {tb[7], tb};
            if (ts[8] != ts[7]) begin
                c_w[8*l +: 8] = ts[8] ? 8'h80 : 8'h7F;
                w_sat         = w_sat + 8'd1;
            end else begin
                c_w[8*l +: 8] = ts[7:0];
            end
            if (ta > w_max)
                w_max = ta;
        end
    end

    // Stage-2 accumulate and command-entry bias, both saturated.
    logic signed [33:0] acc_sum;
    logic [32:0]        acc_fold, bias_fold;
    logic               is_dot;
    logic [31:0]        res_nxt;

    assign acc_sum   = {{2{acc[31]}}, acc} + {{2{s1_dot[31]}}, s1_dot};
    assign acc_fold  = sat_acc(acc_sum);
    assign bias_fold = sat_acc({{2{bus.bias_in[31]}}, bus.bias_in});
    assign is_dot    = (op_r == OP_DOT) || (op_r == OP_RELU);

    always_comb begin
        res_nxt = '0;
        case (op_r)
            OP_DOT:  res_nxt = acc;
            OP_ADD:  res_nxt = sat_cnt;
            OP_MAX:  res_nxt = {{24{mx[7]}}, mx};
            OP_RELU: res_nxt = acc[31] ? 32'd0 : acc;
            default: res_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= '0;
            sat_q    <= 1'b0;
            op_r     <= OP_DOT;
            len_r    <= '0;
            idx      <= '0;
            acc      <= '0;
            mx       <= 8'sh80;
            sat_cnt  <= '0;
            s1_vld   <= 1'b0;
            s1_dot   <= '0;
            s1_max   <= 8'sh80;
            s1_sat   <= '0;
        end else begin
            done_q <= 1'b0;
            s1_vld <= 1'b0;
            if (s1_vld) begin
                acc     <= acc_fold[31:0];
                sat_cnt <= sat_cnt + {24'd0, s1_sat}
                         + {31'd0, acc_fold[32] & is_dot};
                if (s1_max > mx)
                    mx <= s1_max;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_r    <= bus.op_mode;
                        len_r   <= (bus.len_in > LEN_MAX) ? LEN_MAX : bus.len_in;
                        idx     <= '0;
                        acc     <= bias_fold[31:0];
                        sat_cnt <= {31'd0, bias_fold[32]};
                        mx      <= 8'sh80;
                        ready_q <= 1'b0;
                        state   <= (bus.len_in == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    s1_vld <= 1'b1;
                    s1_dot <= w_dot;
                    s1_max <= w_max;
                    s1_sat <= (op_r == OP_ADD) ? w_sat : 8'd0;
                    idx    <= idx + AW'(1);
                    if ({1'b0, idx} == len_r - (AW + 1)'(1))
                        state <= DRAIN;
                end
                DRAIN: state <= DONE;
                DONE: begin
                    state    <= IDLE;
                    ready_q  <= 1'b1;
                    done_q   <= 1'b1;
                    result_q <= res_nxt;
                    sat_q    <= (sat_cnt != '0);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Banks have no reset so host data survives an abort.
    always_ff @(posedge clk) begin
        if (bus.mem_we && ready_q) begin
            if (bank == 2'd0)
                bank_a[word] <= bus.mem_data_in;
            if (bank == 2'd1)
                bank_b[word] <= bus.mem_data_in;
        end
        if (state == RUN && op_r == OP_ADD)
            bank_c[idx] <= c_w;
    end

`ifdef ML_ACC_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_cnt <= '0;
        else if (bus.mem_we && ready_q && bank == 2'd3 && word == AW'(1))
            perf_cnt <= '0;
        else if (state != IDLE && perf_cnt != 32'hFFFF_FFFF)
            perf_cnt <= perf_cnt + 32'd1;
    end
`else
    assign perf_cnt = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (bus.mem_re) begin
            case (bank)
                2'd0: rdata_q <= bank_a[word];
                2'd1: rdata_q <= bank_b[word];
                2'd2: rdata_q <= bank_c[word];
                default: begin
                    if (word == '0)
                        rdata_q <= {{(W - 2){1'b0}}, sat_q, ready_q};
                    else if (word == AW'(1))
                        rdata_q <= W'(perf_cnt);
                    else
                        rdata_q <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_npu_vec_engine.sv
// tb_npu_vec_engine: vector table plus hand sequences for npu_vec_engine.
// Expected results are queued on start and popped on done.
module tb_npu_vec_engine;
    localparam int LANES = 4;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    npu_vec_engine_if #(.LANES(LANES), .DEPTH(DEPTH)) bus ();

    npu_vec_engine #(.LANES(LANES), .DEPTH(DEPTH), .ACC_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [AW:0] len;
        logic [31:0] bias;
        logic [31:0] a0, a1, b0, b1;
        logic [31:0] res;
        logic        sat;
        int          lat;
        logic [31:0] c0;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    always @(negedge clk) if (bus.done) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] bank, input int word, input logic [31:0] data);
        bus.mem_addr    = {bank, AW'(word)};
        bus.mem_data_in = data;
        bus.mem_we      = 1'b1;
        @(negedge clk);
        bus.mem_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] bank, input int word, output logic [31:0] data);
        bus.mem_addr = {bank, AW'(word)};
        bus.mem_re   = 1'b1;
        @(negedge clk);
        bus.mem_re = 1'b0;
        data = bus.mem_data_out;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [AW:0] len, input logic [31:0] bias,
                           input logic [31:0] res, input logic sat, input int lat,
                           input bit poke, input string name);
        exp_t e;
        int   cyc;
        e.res = res;
        e.sat = sat;
        sb.push_back(e);
        bus.op_mode = op;
        bus.len_in  = len;
        bus.bias_in = bias;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.mem_we = 1'b0;
        cyc = 0;
        do begin
            if (poke && cyc == 3) begin
                bus.start       = 1'b1;
                bus.mem_we      = 1'b1;
                bus.mem_addr    = {2'd0, AW'(5)};
                bus.mem_data_in = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            cyc++;
            if (poke && cyc == 4) begin
                check({name, " busy ready"}, {31'd0, bus.ready}, 32'd0);
                bus.start  = 1'b0;
                bus.mem_we = 1'b0;
            end
        end while (!bus.done && cyc < 200);
        check({name, " latency"}, cyc, lat);
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s scoreboard: got done expected queued entry", name);
        end else begin
            e = sb.pop_front();
            check({name, " result"}, bus.result, e.res);
            check({name, " sat_flag"}, {31'd0, bus.sat_flag}, {31'd0, e.sat});
        end
        check({name, " ready at done"}, {31'd0, bus.ready}, 32'd1);
        @(negedge clk);
        check({name, " done width"}, {31'd0, bus.done}, 32'd0);
    endtask

    vec_t        vt[9];
    logic [31:0] d;
    int          dc;
    logic [31:0] exp_perf;

    initial begin
        vt[0] = '{2'b00, 7'd1, 32'd10, 32'h01020304, 32'h0, 32'h01010101, 32'h0,
                  32'h00000014, 1'b0, 3, 32'h0};
        vt[1] = '{2'b01, 7'd1, 32'd0, 32'h7F7F8001, 32'h0, 32'h01028080, 32'h0,
                  32'd3, 1'b1, 3, 32'h7F7F8081};
        vt[2] = '{2'b10, 7'd2, 32'd0, 32'h80FF0102, 32'h057F0000, 32'h0, 32'h0,
                  32'h0000007F, 1'b0, 4, 32'h0};
        vt[3] = '{2'b11, 7'd1, 32'd0, 32'hFFFFFFFF, 32'h0, 32'h01010101, 32'h0,
                  32'h0, 1'b0, 3, 32'h0};
        vt[4] = '{2'b10, 7'd0, 32'd0, 32'h7F7F7F7F, 32'h0, 32'h0, 32'h0,
                  32'hFFFFFF80, 1'b0, 1, 32'h0};
        vt[5] = '{2'b00, 7'd2, -32'sd5, 32'h01020304, 32'hFFFFFFFF, 32'h01010101, 32'h02020202,
                  32'hFFFFFFFD, 1'b0, 4, 32'h0};
        vt[6] = '{2'b11, 7'd2, 32'd100, 32'h01020304, 32'hFFFFFFFF, 32'h01010101, 32'h02020202,
                  32'h00000066, 1'b0, 4, 32'h0};
        vt[7] = '{2'b00, 7'd1, 32'h7FFFFFF0, 32'h7F7F7F7F, 32'h0, 32'h7F7F7F7F, 32'h0,
                  32'h7FFFFFFF, 1'b1, 3, 32'h0};
        vt[8] = '{2'b01, 7'd1, 32'd0, 32'h01020304, 32'h0, 32'h01010101, 32'h0,
                  32'd0, 1'b0, 3, 32'h02030405};

        bus.start       = 1'b0;
        bus.op_mode     = 2'b00;
        bus.len_in      = '0;
        bus.bias_in     = '0;
        bus.mem_addr    = '0;
        bus.mem_we      = 1'b0;
        bus.mem_re      = 1'b0;
        bus.mem_data_in = '0;

        repeat (2) @(negedge clk);
        check("reset ready", {31'd0, bus.ready}, 32'd1);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset sat_flag", {31'd0, bus.sat_flag}, 32'd0);
        check("reset mem_data_out", bus.mem_data_out, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            wr(2'd0, 0, vt[i].a0);
            wr(2'd0, 1, vt[i].a1);
            wr(2'd1, 0, vt[i].b0);
            wr(2'd1, 1, vt[i].b1);
            run_cmd(vt[i].op, vt[i].len, vt[i].bias, vt[i].res, vt[i].sat,
                    vt[i].lat, 1'b0, $sformatf("vec%0d", i));
            if (vt[i].op == 2'b01) begin
                rd(2'd2, 0, d);
                check($sformatf("vec%0d C0", i), d, vt[i].c0);
            end
        end

        // status word 0 reflects last command (vec8: no saturation)
        rd(2'd3, 0, d);
        check("status word0", d, 32'h1);

        // Writes to C are dropped
        wr(2'd2, 0, 32'hFFFFFFFF);
        rd(2'd2, 0, d);
        check("C write ignored", d, 32'h02030405);

        // len clamp: 100 requested, 64 processed
        for (int i = 0; i < DEPTH; i++) begin
            wr(2'd0, i, 32'h01010101);
            wr(2'd1, i, 32'h01010101);
        end
        run_cmd(2'b00, 7'd100, 32'd0, 32'h100, 1'b0, 66, 1'b0, "clamp");

        // start and A write during RUN are ignored
        dc = done_cnt;
        run_cmd(2'b00, 7'd8, 32'd0, 32'h20, 1'b0, 10, 1'b1, "busy");
        repeat (4) @(negedge clk);
        check("busy single done", done_cnt - dc, 32'd1);
        rd(2'd0, 5, d);
        check("busy A unchanged", d, 32'h01010101);

        // reset in the middle of a run
        bus.op_mode = 2'b00;
        bus.len_in  = 7'd64;
        bus.bias_in = 32'd0;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        dc  = done_cnt;
        rst = 1'b1;
        #1;
        check("abort ready", {31'd0, bus.ready}, 32'd1);
        check("abort result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("abort no done", done_cnt - dc, 32'd0);
        rd(2'd3, 1, d);
        check("perf after reset", d, 32'd0);
        run_cmd(2'b00, 7'd64, 32'd0, 32'h100, 1'b0, 66, 1'b0, "rerun");

`ifdef ML_ACC_PERF_CNT_EN
        exp_perf = 32'd66;
`else
        exp_perf = 32'd0;
`endif
        rd(2'd3, 1, d);
        check("perf count", d, exp_perf);
        wr(2'd3, 1, 32'd0);
        rd(2'd3, 1, d);
        check("perf clear", d, 32'd0);

        // write and start in the same IDLE cycle: command sees new data
        bus.mem_addr    = {2'd0, AW'(0)};
        bus.mem_data_in = 32'h02020202;
        bus.mem_we      = 1'b1;
        run_cmd(2'b00, 7'd1, 32'd0, 32'h8, 1'b0, 3, 1'b0, "same-cycle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
